// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants and types used by the datapath registers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sap1_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 8;
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : sap1_pkg

// File: rtl/sap1_mar.sv
// SAP-1 Memory Address Register: captures the low W-bus nibble on load, drives RAM address.
// Latency: one rising clk edge from load/w_bus to RAM_address; output is purely registered.
// Backpressure: none; load is a one-cycle enable, sampled on every edge it is high.
//
// Ports:
//   clk         - system clock, rising-edge state updates
//   rst_n       - asynchronous active-low reset, clears the address to 0
//   load        - active-high capture enable (controller Lm)
//   w_bus       - low ADDR_WIDTH bits of the W bus
//   RAM_address - registered address to the program/data RAM
module sap1_mar #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] w_bus,
    output logic [ADDR_WIDTH-1:0] RAM_address
);

    import sap1_pkg::*;

    logic [ADDR_WIDTH-1:0] r_addr;

    // Reset dominates a coincident load edge; w_bus is captured as-is
    // (no filtering of unknowns) so bus faults stay visible downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (load) begin
            r_addr <= w_bus;
        end
    end

    // Straight from the flop: no combinational path from w_bus/load.
    assign RAM_address = r_addr;

endmodule : sap1_mar

// File: tb/tb_sap1_mar.sv
module tb_sap1_mar;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] w_bus;
    logic [3:0] RAM_address;

    int vectors;
    int miscompares;

    sap1_mar #(.ADDR_WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .w_bus      (w_bus),
        .RAM_address(RAM_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge (safe drive/sample point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] v;
        logic [3:0] prev;
        vectors     = 0;
        miscompares = 0;

        // Reset held with load active: output pinned at 0.
        rst_n = 1'b0;
        load  = 1'b1;
        w_bus = 4'b1010;
        #2;
        check("rst_initial", RAM_address, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_load", RAM_address, 4'b0000);
        end

        // Release between edges; capture only on the following edge.
        rst_n = 1'b1;
        #1;
        check("rst_release_pre_edge", RAM_address, 4'b0000);
        tick();
        check("first_load", RAM_address, 4'b1010);

        // Keep loading the same value.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("load_repeat", RAM_address, 4'b1010);
        end

        // Hold while the bus changes.
        load  = 1'b0;
        w_bus = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold", RAM_address, 4'b1010);
        end

        // Reload: visible only after the edge.
        load = 1'b1;
        #1;
        check("reload_pre_edge", RAM_address, 4'b1010);
        tick();
        check("reload", RAM_address, 4'b0101);

        // Sweep 0..15 then wrap to 0; each value appears one edge later.
        prev = 4'b0101;
        for (int i = 0; i < 17; i++) begin
            v     = 4'(i);
            w_bus = v;
            #1;
            check("sweep_pre_edge", RAM_address, prev);
            tick();
            check("sweep", RAM_address, v);
            prev = v;
        end

        // Async reset mid-hold.
        w_bus = 4'b1111;
        tick();
        check("load_ffff", RAM_address, 4'b1111);
        load  = 1'b0;
        w_bus = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_immediate", RAM_address, 4'b0000);
        tick();
        check("async_rst_held", RAM_address, 4'b0000);
        rst_n = 1'b1;
        w_bus = 4'b1001;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("post_rst_no_load", RAM_address, 4'b0000);
        end
        load  = 1'b1;
        w_bus = 4'b0011;
        tick();
        check("post_rst_load", RAM_address, 4'b0011);

        // Reset asserted coincident with a load edge carrying 0110.
        w_bus = 4'b0110;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_load_collision", RAM_address, 4'b0000);
        tick();
        check("collision_held", RAM_address, 4'b0000);
        rst_n = 1'b1;
        tick();
        check("collision_recover", RAM_address, 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sap1_mar
